// File: rtl/snoop_responder.sv
// snoop_responder: listening-side MSI snoop controller for one processor.
// Samples bus messages from other processors, looks the tag up in a private
// 4-line directory, reports sharing, writes back Modified data through a
// req/ack handshake, then downgrades or invalidates the line.
module snoop_responder #(
  parameter logic [1:0] MY_ID = 2'd0
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       snoop_en,
  input  logic [9:0] bus,
  input  logic       wb_ack,
  input  logic       fill_en,
  input  logic [2:0] fill_tag,
  input  logic [2:0] fill_data,
  input  logic [1:0] fill_state,
  output logic       shared,
  output logic       wb_req,
  output logic [9:0] bus_out,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, UPDATE} state_t;

  state_t state;
  state_t next_state;

  logic [1:0] msg_op;
  logic [2:0] msg_tag;

  logic [1:0] dir_state [4];
  logic       dir_tag   [4];
  logic [2:0] dir_data  [4];

  logic [1:0] snoop_idx;
  logic [1:0] fill_idx;
  logic       hit;
  logic       accept;
  logic       fill_ok;
  logic [1:0] fill_state_norm;
  logic       unused_bus_data;

  // The data field of a snooped message carries nothing the listener needs.
  assign unused_bus_data = ^bus[2:0];

  assign snoop_idx       = msg_tag[1:0];
  assign fill_idx        = fill_tag[1:0];
  assign hit             = (dir_tag[snoop_idx] == msg_tag[2]) && (dir_state[snoop_idx] != ST_I);
  assign accept          = (state == IDLE) && snoop_en && (bus[9:8] != OP_NONE) && (bus[7:6] != MY_ID);
  assign fill_ok         = (state == IDLE) && !snoop_en && fill_en;
  assign fill_state_norm = (fill_state == 2'b11) ? ST_I : fill_state;

  assign busy    = (state != IDLE);
  assign wb_req  = (state == WB);
  assign bus_out = wb_req ? {OP_INV, MY_ID, msg_tag, dir_data[snoop_idx]} : 10'd0;

  // State register; clear returns to IDLE and abandons any pending write-back.
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: a Modified hit on a read or write miss needs a write-back.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (accept) next_state = LOOKUP;
      LOOKUP: begin
        if (hit && (dir_state[snoop_idx] == ST_M) && ((msg_op == OP_RD) || (msg_op == OP_WR)))
          next_state = WB;
        else
          next_state = UPDATE;
      end
      WB:     if (wb_ack) next_state = UPDATE;
      UPDATE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Message latch, shared flag, done pulse, and directory fill/state updates.
  always_ff @(posedge clock) begin
    if (clear) begin
      msg_op  <= OP_NONE;
      msg_tag <= 3'd0;
      shared  <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        dir_state[i] <= ST_I;
        dir_tag[i]   <= 1'b0;
        dir_data[i]  <= 3'd0;
      end
    end else begin
      done <= (state == UPDATE);
      if (accept) begin
        msg_op  <= bus[9:8];
        msg_tag <= bus[5:3];
      end
      if (state == LOOKUP) shared <= hit;
      if (fill_ok) begin
        dir_state[fill_idx] <= fill_state_norm;
        dir_tag[fill_idx]   <= fill_tag[2];
        dir_data[fill_idx]  <= fill_data;
      end
      if ((state == UPDATE) && hit) begin
        case (msg_op)
          OP_RD:         dir_state[snoop_idx] <= ST_S;
          OP_WR, OP_INV: dir_state[snoop_idx] <= ST_I;
          default:       dir_state[snoop_idx] <= dir_state[snoop_idx];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snoop_responder.sv
// Self-checking bench for snoop_responder (MY_ID = 0). Expected shared
// results are queued when a snoop is driven and compared when done pulses.
module tb_snoop_responder;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;
  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       snoop_en = 1'b0;
  logic [9:0] bus = 10'd0;
  logic       wb_ack = 1'b0;
  logic       fill_en = 1'b0;
  logic [2:0] fill_tag = 3'd0;
  logic [2:0] fill_data = 3'd0;
  logic [1:0] fill_state = 2'd0;
  logic       shared;
  logic       wb_req;
  logic [9:0] bus_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;
  logic exp_q[$];

  snoop_responder #(.MY_ID(2'd0)) dut (
    .clock(clock), .clear(clear), .snoop_en(snoop_en), .bus(bus),
    .wb_ack(wb_ack), .fill_en(fill_en), .fill_tag(fill_tag),
    .fill_data(fill_data), .fill_state(fill_state), .shared(shared),
    .wb_req(wb_req), .bus_out(bus_out), .busy(busy), .done(done)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clock = ~clock;

  // Hard stop so a hung design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_fill(input logic [2:0] tag, input logic [2:0] data, input logic [1:0] st);
    @(negedge clock);
    fill_en = 1'b1; fill_tag = tag; fill_data = data; fill_state = st;
    @(negedge clock);
    fill_en = 1'b0;
  endtask

  // Drives one snoop and follows it to its done pulse, optionally with a
  // write-back held for 'hold' cycles before the ack.
  task automatic apply_stimulus(input logic [1:0] op, input logic [1:0] src, input logic [2:0] tag,
                                input logic exp_shared, input logic exp_wb, input logic [9:0] exp_bus,
                                input int hold, input logic with_fill, input string name);
    int waited;
    logic exp_pop;
    @(negedge clock);
    snoop_en = 1'b1; bus = {op, src, tag, 3'b000};
    fill_en = with_fill;
    exp_q.push_back(exp_shared);
    @(negedge clock);
    snoop_en = 1'b0; bus = 10'd0; fill_en = 1'b0;
    check_output({name, "_busy"}, busy, 1);
    @(negedge clock);
    check_output({name, "_shared_t2"}, shared, exp_shared);
    check_output({name, "_wbreq"}, wb_req, exp_wb);
    if (exp_wb) begin
      check_output({name, "_busout"}, bus_out, exp_bus);
      for (int i = 0; i < hold; i++) begin
        if (i == 0) begin
          snoop_en = 1'b1; bus = {OP_RD, 2'd1, 3'b010, 3'b000};
        end else begin
          snoop_en = 1'b0; bus = 10'd0;
        end
        @(negedge clock);
        check_output({name, "_hold_req"}, wb_req, 1);
        check_output({name, "_hold_bus"}, bus_out, exp_bus);
      end
      snoop_en = 1'b0; bus = 10'd0;
      wb_ack = 1'b1;
      @(negedge clock);
      wb_ack = 1'b0;
      check_output({name, "_ack_req"}, wb_req, 0);
      check_output({name, "_ack_bus"}, bus_out, 0);
      check_output({name, "_ack_done"}, done, 0);
    end
    waited = 0;
    while (!done && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    check_output({name, "_done_seen"}, done, 1);
    exp_pop = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
    if (done) check_output({name, "_sb_shared"}, shared, exp_pop);
    @(negedge clock);
    check_output({name, "_done_pulse"}, done, 0);
    check_output({name, "_idle"}, busy, 0);
  endtask

  // Observes n cycles and requires no snoop activity at all.
  task automatic expect_idle(input int n, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (done || busy) seen = 1'b1;
    end
    check_output(name, seen, 0);
  endtask

  task automatic drop_snoop(input logic [1:0] op, input logic [1:0] src, input logic [2:0] tag, input string name);
    @(negedge clock);
    snoop_en = 1'b1; bus = {op, src, tag, 3'b000};
    @(negedge clock);
    snoop_en = 1'b0; bus = 10'd0;
    check_output({name, "_busy"}, busy, 0);
    expect_idle(3, name);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    check_output("rst_shared", shared, 0);
    check_output("rst_wbreq", wb_req, 0);
    check_output("rst_busout", bus_out, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);

    // Miss on an empty directory.
    apply_stimulus(OP_RD, 2'd1, 3'b101, 1'b0, 1'b0, 10'd0, 0, 1'b0, "rd_miss");

    // Modified hit on a read miss: write-back held three cycles, stray snoop ignored.
    apply_fill(3'd5, 3'b110, ST_M);
    apply_stimulus(OP_RD, 2'd2, 3'd5, 1'b1, 1'b1, 10'b11_00_101_110, 3, 1'b0, "rd_m");
    expect_idle(4, "wb_stray_snoop");
    apply_stimulus(OP_RD, 2'd3, 3'd5, 1'b1, 1'b0, 10'd0, 0, 1'b0, "rd_s_after_wb");

    // Shared line invalidated by a write miss.
    apply_fill(3'd2, 3'b001, ST_S);
    apply_stimulus(OP_WR, 2'd1, 3'd2, 1'b1, 1'b0, 10'd0, 0, 1'b0, "wr_s");
    apply_stimulus(OP_WR, 2'd1, 3'd2, 1'b0, 1'b0, 10'd0, 0, 1'b0, "wr_again");

    // Invalidate of a Modified line: no write-back.
    apply_fill(3'd6, 3'b111, ST_M);
    apply_stimulus(OP_INV, 2'd1, 3'd6, 1'b1, 1'b0, 10'd0, 0, 1'b0, "inv_m");
    apply_stimulus(OP_RD, 2'd2, 3'd6, 1'b0, 1'b0, 10'd0, 0, 1'b0, "rd_after_inv");

    // Tag alias on index 1.
    apply_fill(3'd1, 3'b010, ST_S);
    apply_stimulus(OP_RD, 2'd1, 3'd5, 1'b0, 1'b0, 10'd0, 0, 1'b0, "alias");
    apply_stimulus(OP_RD, 2'd1, 3'd1, 1'b1, 1'b0, 10'd0, 0, 1'b0, "alias_keep");

    // Own-source and empty messages are dropped; shared holds.
    drop_snoop(OP_RD, 2'd0, 3'd1, "own_src");
    drop_snoop(OP_NONE, 2'd1, 3'd1, "op_none");
    check_output("shared_hold", shared, 1);

    // Fill state 11 installs an invalid line.
    apply_fill(3'd4, 3'b101, 2'b11);
    apply_stimulus(OP_RD, 2'd1, 3'd4, 1'b0, 1'b0, 10'd0, 0, 1'b0, "fill_11");

    // Fill in the same cycle as a snoop is dropped.
    fill_tag = 3'd3; fill_data = 3'b011; fill_state = ST_M;
    apply_stimulus(OP_WR, 2'd2, 3'd3, 1'b0, 1'b0, 10'd0, 0, 1'b1, "fill_collide");
    apply_stimulus(OP_RD, 2'd2, 3'd3, 1'b0, 1'b0, 10'd0, 0, 1'b0, "fill_dropped");

    // Reset while a write-back is pending.
    apply_fill(3'd7, 3'b010, ST_M);
    @(negedge clock);
    snoop_en = 1'b1; bus = {OP_RD, 2'd1, 3'd7, 3'b000};
    @(negedge clock);
    snoop_en = 1'b0; bus = 10'd0;
    @(negedge clock);
    check_output("rstwb_pre_req", wb_req, 1);
    check_output("rstwb_pre_bus", bus_out, 10'b11_00_111_010);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check_output("rstwb_req", wb_req, 0);
    check_output("rstwb_busy", busy, 0);
    check_output("rstwb_shared", shared, 0);
    check_output("rstwb_busout", bus_out, 0);
    apply_stimulus(OP_RD, 2'd1, 3'd7, 1'b0, 1'b0, 10'd0, 0, 1'b0, "rstwb_line7");
    apply_stimulus(OP_RD, 2'd1, 3'd1, 1'b0, 1'b0, 10'd0, 0, 1'b0, "rstwb_line1");

    check_output("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snoop_responder.md
# snoop_responder

Listening-side snoop controller for one processor in the MSI snooping system. It samples a bus message when its processor is enabled to listen, and looks the tag up in a private 4-line cache directory. It reports `shared` back to the issuing side, writes back Modified data through a req/ack handshake, and downgrades or invalidates the line. One instance sits per CPU, beside the bus arbiter, and answers the transactions issued by the acting processor.

## Interface
- `MY_ID`, default 2'd0: processor id; messages whose source field equals `MY_ID` are ignored.
- `clock` in 1: sole clock, rising edge.
- `clear` in 1: synchronous, active-high reset.
- `snoop_en` in 1: sample `bus` this cycle (listening enable).
- `bus` in 10: message; [9:8] op (00 none, 01 read miss, 10 write miss, 11 invalidate), [7:6] source id, [5:3] tag, [2:0] data.
- `wb_ack` in 1: arbiter accepted `bus_out`.
- `fill_en` in 1: install a line from the local processor side.
- `fill_tag` in 3: tag to install.
- `fill_data` in 3: data to install.
- `fill_state` in 2: state to install (00 I, 01 S, 10 M; 11 treated as I).
- `shared` out 1: the looked-up tag is present (S or M) in this cache.
- `wb_req` out 1: write-back request.
- `bus_out` out 10: write-back message {2'b11, MY_ID, tag, data}; 0 when `wb_req` is low.
- `busy` out 1: FSM not in IDLE.
- `done` out 1: one-cycle pulse at the end of every accepted snoop.

## Operation
- Directory: 4 entries, index = tag[1:0], stored tag bit = tag[2]. Each entry holds a 2-bit state and 3-bit data.
- Hit: index matches, stored tag bit matches, and state ≠ I.
- FSM states: IDLE, LOOKUP, WB, UPDATE.
- IDLE:
  - `snoop_en`=1 with op≠00 and source≠`MY_ID`: latch `bus`, go to LOOKUP.
  - Otherwise: stay in IDLE. `snoop_en` with op 00 or own source is dropped, with no `done`.
- LOOKUP: register `shared` = hit.
  - Hit with state M and op 01 or 10: go to WB.
  - Otherwise: go to UPDATE.
- WB: hold `wb_req`=1 and `bus_out` stable until `wb_ack`=1. On the ack edge, drop `wb_req`, clear `bus_out`, and go to UPDATE.
- UPDATE transitions, then pulse `done` and return to IDLE:
  - Read miss: M→S, S→S.
  - Write miss: S→I, M→I.
  - Invalidate: S→I, M→I with no write-back.
  - Miss: no change.
  - Data is never altered by a snoop.
- Fill: accepted only in IDLE with `snoop_en`=0. Writes tag bit, data and state into the entry at index `fill_tag[1:0]`, overwriting it unconditionally.
  - In any other state, or when `snoop_en`=1 in the same cycle, the fill is ignored; the snoop has priority.
- `shared` holds its value until the next LOOKUP; it is cleared only by reset.
- `snoop_en` while `busy`: ignored. It is not queued.
- `wb_ack` outside WB: ignored.

## Timing
- Reset values (on the clock edge with `clear`=1, overriding everything):
  - FSM → IDLE.
  - All entries → state I, tag 0, data 0.
  - `shared`=0, `wb_req`=0, `bus_out`=0, `busy`=0, `done`=0.
- Reset mid-WB: the request is abandoned and `wb_req` falls on the reset edge.
- Snoop sampled at edge T:
  - `shared` is valid after edge T+1, two cycles after `snoop_en` was presented. The issuing side reads it in its second cycle after enabling the listener.
  - No write-back: UPDATE at T+1→T+2, `done` high for the cycle after edge T+2, next snoop accepted at edge T+3.
  - Write-back: `wb_req` rises at edge T+1. With ack sampled at edge A, UPDATE runs after A and `done` is high after A+1.
- `busy` is high from edge T to the edge that returns the FSM to IDLE.
- A fill takes effect after its edge and is visible to a snoop sampled on the next edge.

## Test plan
- Reset, then read miss with tag 3'b101 from id 1 (MY_ID=0) → `shared`=0 two cycles later, no `wb_req`, single `done`, directory unchanged.
- Fill tag 5, data 3'b110, state M; read miss tag 5 from id 2 → `shared`=1, `wb_req`=1 with `bus_out`=10'b11_00_101_110. Hold `wb_ack` low 3 cycles: output stable. After ack, entry becomes S and `done` pulses.
- Fill tag 2 in S; write miss tag 2 → `shared`=1, no `wb_req`, entry → I. A repeated write miss → `shared`=0.
- Fill tag 6 in M; invalidate tag 6 → no `wb_req`, entry → I. Tag-alias check: fill tag 1 in S, snoop tag 5 (same index, different tag) → `shared`=0, entry for tag 1 unchanged.
- Message with source = `MY_ID`, or op 00 → stays IDLE, no `done`. `snoop_en` asserted during WB → ignored. `fill_en` together with `snoop_en` in IDLE → fill dropped, snoop processed.
- Assert `clear` while in WB with `wb_req`=1 → next cycle `wb_req`=0, `busy`=0, all entries I, `shared`=0.
